elm_output_layer: RTL
=====================

# elm_output_layer

Output-layer engine of the ELM inference pipeline. It accepts the stream of hidden-neuron activations, multiplies each one by its stored row of ten output weights (beta), and accumulates ten signed 48-bit class scores. It then presents those scores, with a held valid level, to the argmax stage that follows it. It is the producer side of the score interface: its `score_0`..`score_9` and `scores_valid` drive that stage's A..J and `en`, and its `scores_clear` drives that stage's `rst`.

## Interface
- `N_HIDDEN`, default 64: number of hidden activations per inference.
- `HW`, default 16: signed activation width.
- `WW`, default 16: signed weight width.
- `SW`, default 48: score width. Must satisfy `HW+WW+$clog2(N_HIDDEN) <= SW`.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `w_we`, in, 1: weight row write strobe.
- `w_addr`, in, `$clog2(N_HIDDEN)`: hidden index of the row being written.
- `w_data`, in, `10*WW`: ten signed weights. Class k occupies `[k*WW +: WW]`.
- `start`, in, 1: one-cycle pulse that begins an inference.
- `h_valid`, in, 1: activation beat valid.
- `h_data`, in, `HW`: signed activation.
- `h_ready`, out, 1: engine accepts an activation beat.
- `busy`, out, 1: high in ACC or FLUSH.
- `scores_valid`, out, 1: scores complete; held high until `scores_clear`.
- `score_0`..`score_9`, out, `SW` each: signed class scores.
- `scores_clear`, in, 1: consumer done; returns the engine to IDLE.

## Operation
- Weight RAM: `N_HIDDEN` rows of `10*WW` bits.
  - Written only in IDLE or DONE. `w_we` in ACC or FLUSH is ignored.
- FSM states and transitions:
  - IDLE → ACC on `start`. All ten accumulators and the beat counter clear to 0.
  - ACC: `h_ready`=1. Each handshake (`h_valid & h_ready`) accepts beat index `cnt`, `cnt` from 0 to `N_HIDDEN-1`.
  - ACC → FLUSH on acceptance of beat `N_HIDDEN-1`. `h_ready` drops in the next cycle.
  - FLUSH → DONE after the last product has been accumulated.
  - DONE: `scores_valid`=1 and the scores are frozen. DONE → IDLE on `scores_clear`.
- Datapath, two stages:
  - Stage 1, on each handshake: register `h_data` and weight row `cnt`, and form the ten HW×WW signed products (HW+WW bits).
  - Stage 2: sign-extend each product to `SW` and add it to its accumulator.
- Arithmetic: two's-complement, wrapping modulo 2^SW, no saturation. The parameter constraint guarantees no overflow.
- Boundary conditions:
  - `start` outside IDLE is ignored.
  - `scores_clear` in ACC or FLUSH aborts the inference: go to IDLE, flush the pipeline, accumulators become don't-care until the next `start`.
  - `start` and `scores_clear` in the same IDLE cycle: `scores_clear` wins and the engine stays in IDLE.
  - Gaps in `h_valid` stall accumulation with no effect on the result.
  - Scores hold their values through IDLE until the next `start` clears them.

## Timing
- Reset values (asynchronous on `rst_n`=0): state IDLE, `cnt`=0, all accumulators 0, pipeline valid 0, `h_ready`=0, `busy`=0, `scores_valid`=0.
- The weight RAM is not reset.
- `h_ready` goes high in the cycle after the `start` edge.
- Latency: the last beat is accepted at edge E. The product is registered at E, accumulated at E+1, and `scores_valid` is high from E+1 onward.
- Minimum inference: `N_HIDDEN`+2 cycles from `start` to `scores_valid`.
- `scores_valid` falls in the cycle after the `scores_clear` edge.
- Reset mid-operation abandons the inference immediately.

## Structure
- Shared package `elm_pkg`:
  - `N_CLASS`=10
  - `SCORE_W`=48
  - score type `logic signed [SCORE_W-1:0]`
  - FSM state enum {IDLE, ACC, FLUSH, DONE}
- Sub-module `elm_mac_lane`: one signed multiply-accumulate lane (product register plus SW-bit accumulator, with clear and enable). Instantiate it ten times.
- Weight RAM is inferred inside the top block.

## Test plan
- Reset with `rst_n`=0 mid-ACC at beat 5 → all outputs go to reset values asynchronously; a fresh `start` then yields correct scores.
- Weights all +1, `N_HIDDEN` beats of `h_data`=+2, no gaps → all ten scores = 128, `scores_valid` at cycle 66 after `start`.
- Row i has class k weight = k−5, `h_data`=i−32 → each score matches the golden model (class 5 = 0). Random `h_valid` gaps give the same result.
- Extremes: all `h_data`=−32768, all weights=−32768 → every score = 64×2^30 = 68719476736 exactly, with no wrap.
- `w_we` during ACC changing row 0 → result still uses the old weights. `start` asserted in DONE → ignored, `scores_valid` stays high.
- `scores_clear` at beat 10 → IDLE, `h_ready`=0. `start` together with `scores_clear` → stays in IDLE.

Source files
------------

// File: rtl/elm_pkg.sv
// Shared definitions for the ELM output-layer engine: class count, score
// width/type and the engine FSM state encoding.
package elm_pkg;

   localparam int N_CLASS = 10;
   localparam int SCORE_W = 48;

   typedef logic signed [SCORE_W-1:0] score_t;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      FLUSH,
      DONE
   } state_t;

endpackage

// File: rtl/elm_mac_lane.sv
// One signed multiply-accumulate lane: a registered HWxWW product followed
// by a wrapping SW-bit accumulator with synchronous clear and enable.
module elm_mac_lane #(
   parameter int HW = 16,
   parameter int WW = 16,
   parameter int SW = 48
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ld_i,
   input  logic signed [HW-1:0] h_i,
   input  logic signed [WW-1:0] w_i,
   input  logic                 clr_i,
   input  logic                 en_i,
   output logic signed [SW-1:0] acc_o
);

   logic signed [HW+WW-1:0] prod_q;
   logic signed [SW-1:0]    acc_q;
   logic signed [SW-1:0]    acc_d;

   // Next accumulator value; the product is sign-extended to the score width.
   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = acc_q + SW'(prod_q);
      end
   end

   // Stage 1 product register and stage 2 accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= '0;
         acc_q  <= '0;
      end else begin
         if (ld_i) begin
            prod_q <= h_i * w_i;
         end
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/elm_output_layer.sv
// ELM output layer: streams hidden activations against a stored beta weight
// RAM, accumulating ten signed class scores that are then held for argmax.
module elm_output_layer
   import elm_pkg::*;
#(
   parameter int N_HIDDEN = 64,
   parameter int HW       = 16,
   parameter int WW       = 16,
   parameter int SW       = 48
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         w_we,
   input  logic [$clog2(N_HIDDEN)-1:0]  w_addr,
   input  logic [N_CLASS*WW-1:0]        w_data,
   input  logic                         start,
   input  logic                         h_valid,
   input  logic [HW-1:0]                h_data,
   output logic                         h_ready,
   output logic                         busy,
   output logic                         scores_valid,
   output logic [SW-1:0]                score_0,
   output logic [SW-1:0]                score_1,
   output logic [SW-1:0]                score_2,
   output logic [SW-1:0]                score_3,
   output logic [SW-1:0]                score_4,
   output logic [SW-1:0]                score_5,
   output logic [SW-1:0]                score_6,
   output logic [SW-1:0]                score_7,
   output logic [SW-1:0]                score_8,
   output logic [SW-1:0]                score_9,
   input  logic                         scores_clear
);

   localparam int            AW   = $clog2(N_HIDDEN);
   localparam logic [AW-1:0] LAST = AW'(N_HIDDEN - 1);

   logic [N_CLASS*WW-1:0] wmem [N_HIDDEN];
   logic [N_CLASS*WW-1:0] row;

   state_t        state_q;
   logic [AW-1:0] cnt_q;
   logic          h_ready_q;
   logic          busy_q;
   logic          valid_q;
   logic          pv_q;

   logic          hs;
   logic          start_go;
   logic          w_en;
   logic signed [SW-1:0] acc [N_CLASS];

   // h_ready_q is only ever high in ACC, so it alone qualifies a beat.
   assign hs       = h_valid & h_ready_q;
   assign start_go = (state_q == IDLE) & start & ~scores_clear;
   assign w_en     = w_we & ((state_q == IDLE) | (state_q == DONE));
   assign row      = wmem[cnt_q];

   // Weight RAM write port; writes are locked out while an inference runs.
   always_ff @(posedge clk) begin
      if (w_en) begin
         wmem[w_addr] <= w_data;
      end
   end

   // Engine FSM with registered handshake and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         h_ready_q <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_go) begin
                  state_q   <= ACC;
                  cnt_q     <= '0;
                  h_ready_q <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            ACC: begin
               if (scores_clear) begin
                  state_q   <= IDLE;
                  h_ready_q <= 1'b0;
                  busy_q    <= 1'b0;
               end else if (hs) begin
                  cnt_q <= cnt_q + AW'(1);
                  if (cnt_q == LAST) begin
                     state_q   <= FLUSH;
                     h_ready_q <= 1'b0;
                  end
               end
            end
            FLUSH: begin
               // The final product is accumulated on this same edge.
               state_q <= scores_clear ? IDLE : DONE;
               valid_q <= ~scores_clear;
               busy_q  <= 1'b0;
            end
            DONE: begin
               if (scores_clear) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Pipeline valid: a product registered this cycle is accumulated next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv_q <= 1'b0;
      end else begin
         pv_q <= hs & ~scores_clear;
      end
   end

   generate
      for (genvar gi = 0; gi < N_CLASS; gi++) begin : g_lane
         elm_mac_lane #(
            .HW (HW),
            .WW (WW),
            .SW (SW)
         ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .ld_i  (hs),
            .h_i   (h_data),
            .w_i   (row[gi*WW +: WW]),
            .clr_i (start_go),
            .en_i  (pv_q),
            .acc_o (acc[gi])
         );
      end
   endgenerate

   assign h_ready      = h_ready_q;
   assign busy         = busy_q;
   assign scores_valid = valid_q;
   assign score_0      = acc[0];
   assign score_1      = acc[1];
   assign score_2      = acc[2];
   assign score_3      = acc[3];
   assign score_4      = acc[4];
   assign score_5      = acc[5];
   assign score_6      = acc[6];
   assign score_7      = acc[7];
   assign score_8      = acc[8];
   assign score_9      = acc[9];

endmodule
